type_field_extractor: RTL and testbench
=======================================

Name: type_field_extractor

Overview:
- Upstream neighbour of the type-lookup stage in the parser pipeline.
- Accepts a packet header as a stream of fixed-width beats and captures TYPE_NUM type fields at per-field byte offsets.
- Emits the fields as one registered result through a valid/ready handshake; the type-lookup stage matches that result against its rules.
- Buffers one result and back-pressures the header stream while that result is pending.

Parameters:
- DATA_WIDTH, 128, header beat width in bits (BPB = DATA_WIDTH/8 bytes per beat).
- HEAD_BEATS, 4, max beats examined per packet (window = HEAD_BEATS*BPB bytes).
- TYPE_NUM, 4, number of type fields.
- TYPE_WIDTH, 16, type field width in bits (multiple of 8).
- TYPE_OFFSET_WIDTH, 7, per-field offset; MSB = field valid, low bits = start byte address.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_typeOffset  in  TYPE_NUM*TYPE_OFFSET_WIDTH  field j at [j*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH]; sampled on first-beat acceptance.
- i_head_data  in  DATA_WIDTH  header beat; byte 0 = bits [DATA_WIDTH-1 -: 8].
- i_head_valid  in  1  beat valid.
- i_head_last  in  1  final beat of packet.
- o_head_ready  out  1  beat accepted when valid&ready.
- o_type  out  TYPE_NUM*TYPE_WIDTH  field j at [j*TYPE_WIDTH +: TYPE_WIDTH], big-endian.
- o_type_miss  out  TYPE_NUM  field j valid but not fully inside the received bytes.
- o_type_valid  out  1  result valid.
- i_type_ready  in  1  result consumed when valid&ready.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, o_type_valid=0, o_type=0, o_type_miss=0, o_head_ready=1, beat counter=0, latched offsets=0.
- States and transitions:
  - IDLE, ready=1: first beat accepted → latch offsets; last=1 → DONE, else COLLECT.
  - COLLECT, ready=1: last beat accepted → DONE.
  - DONE, ready=0, o_type_valid=1: i_type_ready=1 → IDLE. o_type/o_type_miss stay stable while valid&!ready.
- Beat counter:
  - Increments per accepted beat and saturates at HEAD_BEATS.
  - Beats at index ≥ HEAD_BEATS are accepted and ignored.
- Capture:
  - Byte b of beat k has address k*BPB+b.
  - For each valid field, every byte with address in [off, off+TYPE_WIDTH/8-1] is written into its slot when its beat is accepted.
  - Fields straddling a beat boundary assemble across two beats.
- Capture registers clear to 0 on first-beat acceptance of each packet.
- Miss check, evaluated when the last beat is accepted: o_type_miss[j]=1 if field j is valid and its end byte is ≥ received_bytes or ≥ window size. A missed field reads 0 in o_type.
- Invalid field (offset MSB=0): o_type slice=0, miss=0.
- Latency: o_type_valid rises on the cycle after last-beat acceptance. Minimum one-beat packet cost is 2 cycles (accept, then result handshake). Next packet's first beat is accepted the cycle after the result handshake.
- Simultaneous events: in DONE, valid&ready on the result combined with i_head_valid does not accept the beat that cycle (ready=0 in DONE).
- i_head_valid may drop mid-packet; state holds.
- Reset mid-packet discards all partial state; first beat after reset starts a new packet.

Optional Feature:
- TYPE_EARLY_OUT_EN defined:
  - Result is emitted the cycle after the beat that completes every valid field, without waiting for last.
  - Adds state DRAIN, ready=1: remaining beats are consumed while o_type_valid is held.
  - Block returns to IDLE only after both last has been accepted and the result is handshaked. If the result is handshaked first, o_type_valid drops and the block stays in DRAIN until last.
  - Miss evaluation for unfinished fields still occurs at last.
  - If no field is valid, the result issues the cycle after the first beat.
- Undefined: behaviour exactly as above; no DRAIN state.

Test Plan:
- 1-beat packet, offsets {valid,12},{valid,14},invalid,invalid; bytes 12..15 = 08 00 45 00 → o_type f0=0x0800, f1=0x4500, f2=f3=0, miss=0000, valid one cycle after the beat.
- 3-beat packet, field0 at byte 15 (straddle), beat0 byte15=0x86, beat1 byte0=0xDD → f0=0x86DD.
- 1-beat packet with field1 at byte 40 → f1=0, o_type_miss=0010; field1 at byte 63 with 4 beats → miss (end byte 64 outside window).
- Hold i_type_ready=0 for 5 cycles with i_head_valid=1 → o_head_ready=0 throughout; o_type stable; next packet's first beat accepted the cycle after the handshake.
- Reset asserted during beat 2 of 4 → o_type_valid=0, o_head_ready=1 immediately; next 1-beat packet extracts correctly with no residue from before reset.
- TYPE_EARLY_OUT_EN, 4-beat packet, fields in beat0 only → o_type_valid in cycle 2, beats 2..4 accepted with valid held; returns to IDLE after last and the handshake.

Source files
------------

// File: rtl/type_field_extractor.sv
// Captures TYPE_NUM big-endian type fields from a beat-serial packet header and
// hands them on through a one-entry valid/ready buffer. Optional: TYPE_EARLY_OUT_EN.
module type_field_extractor #(
  parameter int unsigned DATA_WIDTH        = 128,
  parameter int unsigned HEAD_BEATS        = 4,
  parameter int unsigned TYPE_NUM          = 4,
  parameter int unsigned TYPE_WIDTH        = 16,
  parameter int unsigned TYPE_OFFSET_WIDTH = 7
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_typeOffset,
  input  logic [DATA_WIDTH-1:0]                 i_head_data,
  input  logic                                  i_head_valid,
  input  logic                                  i_head_last,
  output logic                                  o_head_ready,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]        o_type,
  output logic [TYPE_NUM-1:0]                   o_type_miss,
  output logic                                  o_type_valid,
  input  logic                                  i_type_ready
);

  localparam int unsigned BPB    = DATA_WIDTH / 8;
  localparam int unsigned TBYTES = TYPE_WIDTH / 8;
  localparam int unsigned WINDOW = HEAD_BEATS * BPB;
  localparam int unsigned AW     = TYPE_OFFSET_WIDTH - 1;
  localparam int unsigned CW     = $clog2(HEAD_BEATS + 1);
  localparam int unsigned OFW    = TYPE_NUM * TYPE_OFFSET_WIDTH;
  localparam int unsigned TFW    = TYPE_NUM * TYPE_WIDTH;

`ifdef TYPE_EARLY_OUT_EN
  typedef enum logic [1:0] {StIdle, StCollect, StDone, StDrain} state_e;
`else
  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OFW-1:0]        offs_q, offs_d;
  logic [TFW-1:0]        cap_q, cap_d;
  logic [TFW-1:0]        type_q, type_d;
  logic [TYPE_NUM-1:0]   miss_q, miss_d;
  logic                  valid_q, valid_d;

  logic                  head_ready;
  logic                  beat_acc;
  logic                  first;
  logic [OFW-1:0]        offs_eff;
  logic [CW-1:0]         cnt_cur;
  logic [CW-1:0]         cnt_next;
  logic [TFW-1:0]        cap_new;
  logic [TFW-1:0]        res_type;
  logic [TYPE_NUM-1:0]   res_miss;
  int unsigned           addr;
  int unsigned           end_byte;
  int unsigned           recv_bytes;

  assign head_ready = (state_q != StDone);
  assign beat_acc   = i_head_valid & head_ready;
  assign first      = (state_q == StIdle);
  // The first beat uses the live offsets; later beats use the copy latched with it.
  assign offs_eff   = first ? i_typeOffset : offs_q;
  assign cnt_cur    = first ? '0 : cnt_q;
  assign cnt_next   = (cnt_cur == CW'(HEAD_BEATS)) ? cnt_cur : cnt_cur + 1'b1;
  assign recv_bytes = 32'(cnt_next) * BPB;

  // Byte capture for the beat currently on the bus; beats past the window match nothing.
  always_comb begin
    addr    = 0;
    cap_new = first ? '0 : cap_q;
    for (int unsigned j = 0; j < TYPE_NUM; j++) begin
      for (int unsigned i = 0; i < TBYTES; i++) begin
        addr = 32'(offs_eff[j*TYPE_OFFSET_WIDTH +: AW]) + i;
        for (int unsigned b = 0; b < BPB; b++) begin
          if (offs_eff[j*TYPE_OFFSET_WIDTH + AW] && (32'(cnt_cur) < HEAD_BEATS) &&
              (addr == 32'(cnt_cur) * BPB + b)) begin
            cap_new[j*TYPE_WIDTH + TYPE_WIDTH - 1 - 8*i -: 8] =
                i_head_data[DATA_WIDTH - 1 - 8*b -: 8];
          end
        end
      end
    end
  end

  // Result as it would stand if this beat closed the packet.
  always_comb begin
    end_byte = 0;
    res_type = '0;
    res_miss = '0;
    for (int unsigned j = 0; j < TYPE_NUM; j++) begin
      end_byte = 32'(offs_eff[j*TYPE_OFFSET_WIDTH +: AW]) + TBYTES - 1;
      if (offs_eff[j*TYPE_OFFSET_WIDTH + AW]) begin
        if ((end_byte >= recv_bytes) || (end_byte >= WINDOW)) begin
          res_miss[j] = 1'b1;
        end else begin
          res_type[j*TYPE_WIDTH +: TYPE_WIDTH] = cap_new[j*TYPE_WIDTH +: TYPE_WIDTH];
        end
      end
    end
  end

`ifdef TYPE_EARLY_OUT_EN
  // Every valid field already lies inside the received bytes.
  logic all_done;
  assign all_done = ~|res_miss;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    offs_d  = offs_q;
    cap_d   = cap_q;
    type_d  = type_q;
    miss_d  = miss_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle, StCollect: begin
        if (beat_acc) begin
          offs_d = offs_eff;
          cnt_d  = cnt_next;
          cap_d  = cap_new;
          if (i_head_last) begin
            type_d  = res_type;
            miss_d  = res_miss;
            valid_d = 1'b1;
            state_d = StDone;
`ifdef TYPE_EARLY_OUT_EN
          end else if (all_done) begin
            type_d  = res_type;
            miss_d  = '0;
            valid_d = 1'b1;
            state_d = StDrain;
`endif
          end else begin
            state_d = StCollect;
          end
        end
      end
      StDone: begin
        if (i_type_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
`ifdef TYPE_EARLY_OUT_EN
      StDrain: begin
        if (valid_q && i_type_ready) begin
          valid_d = 1'b0;
        end
        if (beat_acc) begin
          cnt_d = cnt_next;
          cap_d = cap_new;
          if (i_head_last) begin
            if (!valid_q || i_type_ready) begin
              valid_d = 1'b0;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      offs_q  <= '0;
      cap_q   <= '0;
      type_q  <= '0;
      miss_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      offs_q  <= offs_d;
      cap_q   <= cap_d;
      type_q  <= type_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  assign o_head_ready = head_ready;
  assign o_type       = type_q;
  assign o_type_miss  = miss_q;
  assign o_type_valid = valid_q;

endmodule

// File: tb/tb_type_field_extractor.sv
// Randomised self-checking bench for type_field_extractor; expected fields come
// from a byte-array model of each packet.
module tb_type_field_extractor;

  localparam int DW  = 128;
  localparam int HB  = 4;
  localparam int TN  = 4;
  localparam int TW  = 16;
  localparam int TOW = 7;
  localparam int BPB = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [TN*TOW-1:0] type_offset = '0;
  logic [DW-1:0]   head_data = '0;
  logic            head_valid = 1'b0;
  logic            head_last = 1'b0;
  logic            head_ready;
  logic [TN*TW-1:0] type_out;
  logic [TN-1:0]   type_miss;
  logic            type_valid;
  logic            type_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] pkt [0:6*BPB-1];

  always #5 clk = ~clk;

  type_field_extractor #(
    .DATA_WIDTH        (DW),
    .HEAD_BEATS        (HB),
    .TYPE_NUM          (TN),
    .TYPE_WIDTH        (TW),
    .TYPE_OFFSET_WIDTH (TOW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_typeOffset (type_offset),
    .i_head_data  (head_data),
    .i_head_valid (head_valid),
    .i_head_last  (head_last),
    .o_head_ready (head_ready),
    .o_type       (type_out),
    .o_type_miss  (type_miss),
    .o_type_valid (type_valid),
    .i_type_ready (type_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Fields read straight from the packet bytes; a field needs both bytes received and in-window.
  task automatic model(input int nb, input logic [TN*TOW-1:0] offs,
                       output logic [TN*TW-1:0] et, output logic [TN-1:0] em);
    int recv;
    int off;
    recv = ((nb < HB) ? nb : HB) * BPB;
    et = '0;
    em = '0;
    for (int j = 0; j < TN; j++) begin
      if (offs[j*TOW + TOW - 1]) begin
        off = int'(offs[j*TOW +: TOW-1]);
        if (off + 1 >= recv || off + 1 >= HB * BPB) em[j] = 1'b1;
        else et[j*TW +: TW] = {pkt[off], pkt[off+1]};
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 6 * BPB; i++) pkt[i] = 8'($urandom);
  endtask

  task automatic load_beat(input int k);
    for (int b = 0; b < BPB; b++) head_data[DW-1-8*b -: 8] = pkt[k*BPB + b];
  endtask

  task automatic run_packet(input int nb, input logic [TN*TOW-1:0] offs, input int hold,
                            output logic [TN*TW-1:0] got_t, output logic [TN-1:0] got_m);
    logic [TN*TW-1:0] et;
    logic [TN-1:0]    em;
    model(nb, offs, et, em);
    for (int k = 0; k < nb; k++) begin
      if (k > 0 && $urandom_range(3) == 0) begin
        head_valid = 1'b0;
        head_last  = 1'b1;
        head_data  = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      load_beat(k);
      head_valid  = 1'b1;
      head_last   = (k == nb - 1);
      type_offset = (k == 0) ? offs : (TN*TOW)'($urandom);
      check_eq("head_ready_in_pkt", 64'(head_ready), 64'd1);
      @(posedge clk); #1;
    end
    check_eq("valid_after_last", 64'(type_valid), 64'd1);
    // A pending junk last-beat must be refused while the result is held.
    head_valid = 1'b1;
    head_last  = 1'b1;
    head_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < hold; c++) begin
      check_eq("hold_ready", 64'(head_ready), 64'd0);
      check_eq("hold_type", 64'(type_out), 64'(et));
      check_eq("hold_miss", 64'(type_miss), 64'(em));
      @(posedge clk); #1;
    end
    got_t = type_out;
    got_m = type_miss;
    check_eq("type", 64'(type_out), 64'(et));
    check_eq("miss", 64'(type_miss), 64'(em));
    check_eq("valid_before_hs", 64'(type_valid), 64'd1);
    type_ready = 1'b1;
    @(posedge clk); #1;
    type_ready = 1'b0;
    head_valid = 1'b0;
    head_last  = 1'b0;
    check_eq("valid_after_hs", 64'(type_valid), 64'd0);
    check_eq("ready_after_hs", 64'(head_ready), 64'd1);
  endtask

  function automatic logic [TOW-1:0] fld(input int off);
    return {1'b1, 6'(off)};
  endfunction

  initial begin
    logic [TN*TW-1:0] gt;
    logic [TN-1:0]    gm;
    logic [TN*TOW-1:0] offs;

    #12;
    check_eq("rst_valid", 64'(type_valid), 64'd0);
    check_eq("rst_ready", 64'(head_ready), 64'd1);
    check_eq("rst_type", 64'(type_out), 64'd0);
    check_eq("rst_miss", 64'(type_miss), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ethertype + IPv4 first word in one beat.
    fill_random();
    pkt[12] = 8'h08; pkt[13] = 8'h00; pkt[14] = 8'h45; pkt[15] = 8'h00;
    run_packet(1, {7'h00, 7'h00, fld(14), fld(12)}, 0, gt, gm);
    check_eq("tp1_type", 64'(gt), 64'h0000_0000_4500_0800);
    check_eq("tp1_miss", 64'(gm), 64'h0);

    // Field straddling beats 0 and 1.
    fill_random();
    pkt[15] = 8'h86; pkt[16] = 8'hDD;
    run_packet(3, {7'h00, 7'h00, 7'h00, fld(15)}, 1, gt, gm);
    check_eq("straddle_type", 64'(gt[15:0]), 64'h86DD);

    // Beyond received bytes, then beyond the window.
    fill_random();
    run_packet(1, {7'h00, 7'h00, fld(40), 7'h00}, 0, gt, gm);
    check_eq("short_miss", 64'(gm), 64'b0010);
    check_eq("short_type", 64'(gt), 64'h0);
    fill_random();
    run_packet(4, {7'h00, 7'h00, fld(63), fld(62)}, 0, gt, gm);
    check_eq("window_miss", 64'(gm), 64'b0010);
    check_eq("window_f0", 64'(gt[15:0]), 64'({pkt[62], pkt[63]}));

    // Long back-pressure, then no valid fields at all.
    fill_random();
    run_packet(2, {fld(20), fld(0), fld(30), fld(3)}, 5, gt, gm);
    fill_random();
    run_packet(2, '0, 1, gt, gm);
    check_eq("novalid_type", 64'(gt), 64'h0);
    check_eq("novalid_miss", 64'(gm), 64'h0);

    // Reset in the middle of a 4-beat packet.
    fill_random();
    for (int k = 0; k < 2; k++) begin
      load_beat(k);
      head_valid  = 1'b1;
      head_last   = 1'b0;
      type_offset = {fld(50), fld(40), fld(20), fld(2)};
      @(posedge clk); #1;
    end
    load_beat(2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(type_valid), 64'd0);
    check_eq("midrst_ready", 64'(head_ready), 64'd1);
    check_eq("midrst_type", 64'(type_out), 64'd0);
    head_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_random();
    run_packet(1, {fld(14), 7'h00, fld(20), fld(5)}, 0, gt, gm);
    check_eq("postrst_miss", 64'(gm), 64'b0010);

    // Randomised packets.
    for (int p = 0; p < 40; p++) begin
      fill_random();
      for (int j = 0; j < TN; j++)
        offs[j*TOW +: TOW] = {($urandom_range(3) != 0), 6'($urandom_range(63))};
      run_packet($urandom_range(1, 6), offs, $urandom_range(0, 3), gt, gm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
